eth_ipv4_hdr_extract: RTL and testbench

//  Passive tap on a 64-bit AXI4-Stream Ethernet RX path. It sits between the MAC RX

---
 rtl/eth_ipv4_hdr_extract.sv | 259 +++++++++++++++++++++++++
 tb/tb_eth_ipv4_hdr_extract.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_ipv4_hdr_extract.sv
// Passive header tap on a 64-bit AXI4-Stream Ethernet RX path: captures L2/L3/L4 fields
// from the first five beats of each frame and strobes them out in host byte order.
module eth_ipv4_hdr_extract #(
    parameter logic [15:0] ETHERTYPE_IPV4 = 16'h0800,
    parameter logic [7:0]  IP_PROTO_UDP   = 8'd17
) (
    input  logic        clk156,
    input  logic        sys_rst_n,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tready,
    input  logic [63:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    output logic        hdr_valid,
    output logic        hdr_runt,
    output logic        is_ipv4,
    output logic        is_udp,
    output logic [47:0] eth_dst,
    output logic [47:0] eth_src,
    output logic [15:0] eth_type,
    output logic [7:0]  ip_ver_ihl,
    output logic [7:0]  ip_proto,
    output logic [31:0] ip_src,
    output logic [31:0] ip_dst,
    output logic [15:0] udp_sport,
    output logic [15:0] udp_dport
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY} state_t;

    // Wire byte 0 of a field sits in the low byte of the raw value; host order puts it at the MSB.
    function automatic logic [15:0] endian_conv16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [31:0] endian_conv32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [47:0] endian_conv48(input logic [47:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24], v[39:32], v[47:40]};
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  beat_q, beat_d;

    logic [47:0] dst_raw_q, dst_raw_d;
    logic [47:0] src_raw_q, src_raw_d;
    logic [15:0] type_raw_q, type_raw_d;
    logic [7:0]  ver_ihl_raw_q, ver_ihl_raw_d;
    logic [7:0]  proto_raw_q, proto_raw_d;
    logic [31:0] ipsrc_raw_q, ipsrc_raw_d;
    logic [31:0] ipdst_raw_q, ipdst_raw_d;
    logic [15:0] sport_raw_q, sport_raw_d;
    logic [15:0] dport_raw_q, dport_raw_d;

    logic        hdr_valid_q, hdr_valid_d;
    logic        hdr_runt_q, hdr_runt_d;
    logic        is_ipv4_q, is_ipv4_d;
    logic        is_udp_q, is_udp_d;
    logic [47:0] eth_dst_q, eth_dst_d;
    logic [47:0] eth_src_q, eth_src_d;
    logic [15:0] eth_type_q, eth_type_d;
    logic [7:0]  ip_ver_ihl_q, ip_ver_ihl_d;
    logic [7:0]  ip_proto_q, ip_proto_d;
    logic [31:0] ip_src_q, ip_src_d;
    logic [31:0] ip_dst_q, ip_dst_d;
    logic [15:0] udp_sport_q, udp_sport_d;
    logic [15:0] udp_dport_q, udp_dport_d;

    logic        accept;
    logic        fire;
    logic        fire_runt;
    logic        ipv4_match;

    assign accept = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        dst_raw_d     = dst_raw_q;
        src_raw_d     = src_raw_q;
        type_raw_d    = type_raw_q;
        ver_ihl_raw_d = ver_ihl_raw_q;
        proto_raw_d   = proto_raw_q;
        ipsrc_raw_d   = ipsrc_raw_q;
        ipdst_raw_d   = ipdst_raw_q;
        sport_raw_d   = sport_raw_q;
        dport_raw_d   = dport_raw_q;
        fire          = 1'b0;
        fire_runt     = 1'b0;

        if (accept) begin
            case (state_q)
                S_IDLE: begin
                    // Every beat 0 clears the capture set so a runt reads zeros past its end.
                    dst_raw_d     = s_axis_tdata[47:0];
                    src_raw_d     = {32'h0, s_axis_tdata[63:48]};
                    type_raw_d    = '0;
                    ver_ihl_raw_d = '0;
                    proto_raw_d   = '0;
                    ipsrc_raw_d   = '0;
                    ipdst_raw_d   = '0;
                    sport_raw_d   = '0;
                    dport_raw_d   = '0;
                    if (s_axis_tlast) begin
                        fire      = 1'b1;
                        fire_runt = 1'b1;
                        beat_d    = 3'd0;
                    end else begin
                        state_d = S_HDR;
                        beat_d  = 3'd1;
                    end
                end
                S_HDR: begin
                    case (beat_q)
                        3'd1: begin
                            src_raw_d[47:16] = s_axis_tdata[31:0];
                            type_raw_d       = s_axis_tdata[47:32];
                            ver_ihl_raw_d    = s_axis_tdata[55:48];
                        end
                        3'd2: proto_raw_d = s_axis_tdata[63:56];
                        3'd3: begin
                            ipsrc_raw_d       = s_axis_tdata[47:16];
                            ipdst_raw_d[15:0] = s_axis_tdata[63:48];
                        end
                        3'd4: begin
                            ipdst_raw_d[31:16] = s_axis_tdata[15:0];
                            sport_raw_d        = s_axis_tdata[31:16];
                            dport_raw_d        = s_axis_tdata[47:32];
                        end
                        default: ;
                    endcase
                    beat_d = (beat_q == 3'd5) ? beat_q : beat_q + 3'd1;
                    if (beat_q == 3'd4) begin
                        fire    = 1'b1;
                        state_d = s_axis_tlast ? S_IDLE : S_BODY;
                        if (s_axis_tlast) beat_d = 3'd0;
                    end else if (s_axis_tlast) begin
                        fire      = 1'b1;
                        fire_runt = 1'b1;
                        state_d   = S_IDLE;
                        beat_d    = 3'd0;
                    end
                end
                S_BODY: begin
                    if (s_axis_tlast) begin
                        state_d = S_IDLE;
                        beat_d  = 3'd0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    beat_d  = 3'd0;
                end
            endcase
        end

        ipv4_match = (endian_conv16(type_raw_d) == ETHERTYPE_IPV4) && (ver_ihl_raw_d == 8'h45);

        hdr_valid_d  = fire;
        hdr_runt_d   = hdr_runt_q;
        is_ipv4_d    = is_ipv4_q;
        is_udp_d     = is_udp_q;
        eth_dst_d    = eth_dst_q;
        eth_src_d    = eth_src_q;
        eth_type_d   = eth_type_q;
        ip_ver_ihl_d = ip_ver_ihl_q;
        ip_proto_d   = ip_proto_q;
        ip_src_d     = ip_src_q;
        ip_dst_d     = ip_dst_q;
        udp_sport_d  = udp_sport_q;
        udp_dport_d  = udp_dport_q;

        // Fields are swapped from the post-beat raw values so the strobe lands one cycle after the trigger.
        if (fire) begin
            hdr_runt_d   = fire_runt;
            is_ipv4_d    = !fire_runt && ipv4_match;
            is_udp_d     = !fire_runt && ipv4_match && (proto_raw_d == IP_PROTO_UDP);
            eth_dst_d    = endian_conv48(dst_raw_d);
            eth_src_d    = endian_conv48(src_raw_d);
            eth_type_d   = endian_conv16(type_raw_d);
            ip_ver_ihl_d = ver_ihl_raw_d;
            ip_proto_d   = proto_raw_d;
            ip_src_d     = endian_conv32(ipsrc_raw_d);
            ip_dst_d     = endian_conv32(ipdst_raw_d);
            udp_sport_d  = endian_conv16(sport_raw_d);
            udp_dport_d  = endian_conv16(dport_raw_d);
        end
    end

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= S_IDLE;
            beat_q        <= 3'd0;
            dst_raw_q     <= '0;
            src_raw_q     <= '0;
            type_raw_q    <= '0;
            ver_ihl_raw_q <= '0;
            proto_raw_q   <= '0;
            ipsrc_raw_q   <= '0;
            ipdst_raw_q   <= '0;
            sport_raw_q   <= '0;
            dport_raw_q   <= '0;
            hdr_valid_q   <= 1'b0;
            hdr_runt_q    <= 1'b0;
            is_ipv4_q     <= 1'b0;
            is_udp_q      <= 1'b0;
            eth_dst_q     <= '0;
            eth_src_q     <= '0;
            eth_type_q    <= '0;
            ip_ver_ihl_q  <= '0;
            ip_proto_q    <= '0;
            ip_src_q      <= '0;
            ip_dst_q      <= '0;
            udp_sport_q   <= '0;
            udp_dport_q   <= '0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            dst_raw_q     <= dst_raw_d;
            src_raw_q     <= src_raw_d;
            type_raw_q    <= type_raw_d;
            ver_ihl_raw_q <= ver_ihl_raw_d;
            proto_raw_q   <= proto_raw_d;
            ipsrc_raw_q   <= ipsrc_raw_d;
            ipdst_raw_q   <= ipdst_raw_d;
            sport_raw_q   <= sport_raw_d;
            dport_raw_q   <= dport_raw_d;
            hdr_valid_q   <= hdr_valid_d;
            hdr_runt_q    <= hdr_runt_d;
            is_ipv4_q     <= is_ipv4_d;
            is_udp_q      <= is_udp_d;
            eth_dst_q     <= eth_dst_d;
            eth_src_q     <= eth_src_d;
            eth_type_q    <= eth_type_d;
            ip_ver_ihl_q  <= ip_ver_ihl_d;
            ip_proto_q    <= ip_proto_d;
            ip_src_q      <= ip_src_d;
            ip_dst_q      <= ip_dst_d;
            udp_sport_q   <= udp_sport_d;
            udp_dport_q   <= udp_dport_d;
        end
    end

    assign hdr_valid  = hdr_valid_q;
    assign hdr_runt   = hdr_runt_q;
    assign is_ipv4    = is_ipv4_q;
    assign is_udp     = is_udp_q;
    assign eth_dst    = eth_dst_q;
    assign eth_src    = eth_src_q;
    assign eth_type   = eth_type_q;
    assign ip_ver_ihl = ip_ver_ihl_q;
    assign ip_proto   = ip_proto_q;
    assign ip_src     = ip_src_q;
    assign ip_dst     = ip_dst_q;
    assign udp_sport  = udp_sport_q;
    assign udp_dport  = udp_dport_q;

endmodule

// File: tb/tb_eth_ipv4_hdr_extract.sv
// Randomized bench for eth_ipv4_hdr_extract: frames are byte arrays, expected headers are
// read straight from byte offsets and checked at every strobe.
module tb_eth_ipv4_hdr_extract;

    logic        clk156 = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic        s_axis_tlast = 1'b0;
    logic        hdr_valid, hdr_runt, is_ipv4, is_udp;
    logic [47:0] eth_dst, eth_src;
    logic [15:0] eth_type, udp_sport, udp_dport;
    logic [7:0]  ip_ver_ihl, ip_proto;
    logic [31:0] ip_src, ip_dst;

    eth_ipv4_hdr_extract dut (
        .clk156(clk156), .sys_rst_n(sys_rst_n),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .hdr_valid(hdr_valid), .hdr_runt(hdr_runt), .is_ipv4(is_ipv4), .is_udp(is_udp),
        .eth_dst(eth_dst), .eth_src(eth_src), .eth_type(eth_type),
        .ip_ver_ihl(ip_ver_ihl), .ip_proto(ip_proto), .ip_src(ip_src), .ip_dst(ip_dst),
        .udp_sport(udp_sport), .udp_dport(udp_dport)
    );

    always #3 clk156 = ~clk156;

    typedef struct {
        logic [47:0] dst, src;
        logic [15:0] typ, sport, dport;
        logic [7:0]  vih, proto;
        logic [31:0] ips, ipd;
        logic        runt, ipv4, udp;
        int          cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    exp_t       last_obs;
    logic [7:0] fbytes [0:255];
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         n_strobe = 0;

    always @(posedge clk156) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put_be(input int off, input int n, input logic [47:0] v);
        for (int i = 0; i < n; i++) fbytes[off + i] = 8'(v >> (8 * (n - 1 - i)));
    endtask

    // Bytes past the last driven beat were never seen, so they read as zero.
    function automatic logic [47:0] get_be(input int off, input int n, input int nb);
        logic [47:0] v = '0;
        for (int i = 0; i < n; i++)
            v = (v << 8) | ((off + i < nb * 8) ? 48'(fbytes[off + i]) : 48'h0);
        return v;
    endfunction

    task automatic build_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                               input logic [7:0] vih, input logic [7:0] proto, input logic [31:0] ips,
                               input logic [31:0] ipd, input logic [15:0] sp, input logic [15:0] dp);
        for (int i = 0; i < 256; i++) fbytes[i] = 8'($urandom);
        put_be(0, 6, dst);   put_be(6, 6, src);   put_be(12, 2, 48'(typ));
        put_be(14, 1, 48'(vih)); put_be(23, 1, 48'(proto));
        put_be(26, 4, 48'(ips)); put_be(30, 4, 48'(ipd));
        put_be(34, 2, 48'(sp));  put_be(36, 2, 48'(dp));
    endtask

    function automatic exp_t make_exp(input int len);
        exp_t e;
        int nb = (len + 7) / 8;
        e.dst   = get_be(0, 6, nb);
        e.src   = get_be(6, 6, nb);
        e.typ   = 16'(get_be(12, 2, nb));
        e.vih   = 8'(get_be(14, 1, nb));
        e.proto = 8'(get_be(23, 1, nb));
        e.ips   = 32'(get_be(26, 4, nb));
        e.ipd   = 32'(get_be(30, 4, nb));
        e.sport = 16'(get_be(34, 2, nb));
        e.dport = 16'(get_be(36, 2, nb));
        e.runt  = (nb < 5);
        e.ipv4  = !e.runt && (e.typ == 16'h0800) && (e.vih == 8'h45);
        e.udp   = e.ipv4 && (e.proto == 8'd17);
        e.cyc   = 0;
        return e;
    endfunction

    function automatic logic [63:0] beat_word(input int b);
        logic [63:0] w;
        for (int l = 0; l < 8; l++) w[8*l +: 8] = fbytes[8*b + l];
        return w;
    endfunction

    task automatic drive_frame(input int len, input bit bubble, input int abort_beat);
        exp_t e = make_exp(len);
        int nb = (len + 7) / 8;
        int trig = (nb >= 5) ? 4 : nb - 1;
        int b = 0;
        int guard = 0;
        while (b < nb) begin
            if (b == abort_beat) begin
                s_axis_tvalid = 1'b0;
                sys_rst_n = 1'b0;
                @(negedge clk156);
                chk("rst_hdr_valid", 64'(hdr_valid), 64'h0);
                chk("rst_flags", {60'h0, hdr_runt, is_ipv4, is_udp, 1'b0}, 64'h0);
                chk("rst_eth_dst", 64'(eth_dst), 64'h0);
                chk("rst_ip_fields", {ip_src, ip_dst}, 64'h0);
                chk("rst_l4_type", {eth_type, udp_sport, udp_dport, ip_ver_ihl, ip_proto}, 64'h0);
                @(posedge clk156); #1;
                sys_rst_n = 1'b1;
                return;
            end
            s_axis_tvalid = bubble ? ($urandom_range(0, 1) == 1) : 1'b1;
            s_axis_tready = bubble ? ($urandom_range(0, 1) == 1) : 1'b1;
            s_axis_tlast  = (b == nb - 1);
            s_axis_tdata  = (s_axis_tvalid && s_axis_tready) ? beat_word(b) : {$urandom, $urandom};
            @(posedge clk156); #1;
            if (s_axis_tvalid && s_axis_tready) begin
                if (b == trig) begin
                    e.cyc = cyc;
                    exp_q.push_back(e);
                end
                b++;
            end
            guard++;
            if (guard > 4000) begin
                chk("drive_timeout", 64'(guard), 64'(4000));
                break;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    always @(negedge clk156) begin
        if (hdr_valid === 1'b1) begin
            n_strobe++;
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 64'h1, 64'h0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("latency", 64'(cyc), 64'(mon_e.cyc));
                chk("hdr_runt", 64'(hdr_runt), 64'(mon_e.runt));
                chk("is_ipv4", 64'(is_ipv4), 64'(mon_e.ipv4));
                chk("is_udp", 64'(is_udp), 64'(mon_e.udp));
                chk("eth_dst", 64'(eth_dst), 64'(mon_e.dst));
                chk("eth_src", 64'(eth_src), 64'(mon_e.src));
                chk("eth_type", 64'(eth_type), 64'(mon_e.typ));
                chk("ip_ver_ihl", 64'(ip_ver_ihl), 64'(mon_e.vih));
                chk("ip_proto", 64'(ip_proto), 64'(mon_e.proto));
                chk("ip_src", 64'(ip_src), 64'(mon_e.ips));
                chk("ip_dst", 64'(ip_dst), 64'(mon_e.ipd));
                chk("udp_sport", 64'(udp_sport), 64'(mon_e.sport));
                chk("udp_dport", 64'(udp_dport), 64'(mon_e.dport));
            end
            last_obs.dst = eth_dst;   last_obs.typ = eth_type;
            last_obs.ips = ip_src;    last_obs.ipd = ip_dst;
            last_obs.sport = udp_sport; last_obs.dport = udp_dport;
            last_obs.udp = is_udp;    last_obs.ipv4 = is_ipv4;
            last_obs.runt = hdr_runt; last_obs.proto = ip_proto;
        end
    end

    task automatic build_udp_ref();
        build_frame(48'h001122334455, 48'h66778899aabb, 16'h0800, 8'h45, 8'h11,
                    32'h0a000001, 32'h0a000002, 16'd1234, 16'd4791);
    endtask

    task automatic check_udp_ref(input string tag, input int strobes_before);
        repeat (4) @(posedge clk156);
        @(negedge clk156);
        chk({tag, "_strobes"}, 64'(n_strobe - strobes_before), 64'h1);
        chk({tag, "_eth_dst"}, 64'(last_obs.dst), 64'h001122334455);
        chk({tag, "_eth_type"}, 64'(last_obs.typ), 64'h0800);
        chk({tag, "_ip"}, {last_obs.ips, last_obs.ipd}, 64'h0a0000010a000002);
        chk({tag, "_ports"}, {32'h0, last_obs.sport, last_obs.dport}, 64'h04d212b7);
        chk({tag, "_is_udp"}, 64'(last_obs.udp), 64'h1);
    endtask

    initial begin
        int s0;
        #1 sys_rst_n = 1'b0;
        repeat (3) @(posedge clk156);
        @(negedge clk156);
        chk("reset_hdr_valid", 64'(hdr_valid), 64'h0);
        chk("reset_eth_dst", 64'(eth_dst), 64'h0);
        chk("reset_ip_src", 64'(ip_src), 64'h0);
        @(posedge clk156); #1;
        sys_rst_n = 1'b1;
        repeat (2) @(posedge clk156); #1;

        s0 = n_strobe; build_udp_ref(); drive_frame(64, 1'b0, -1); check_udp_ref("udp", s0);
        s0 = n_strobe; build_udp_ref(); drive_frame(64, 1'b1, -1); check_udp_ref("udp_bubble", s0);

        build_frame(48'hffffffffffff, 48'h020304050607, 16'h0806, 8'h00, 8'h01,
                    32'h0, 32'h0, 16'h0, 16'h0);
        drive_frame(60, 1'b0, -1);
        repeat (3) @(posedge clk156); @(negedge clk156);
        chk("arp_flags", {61'h0, last_obs.runt, last_obs.ipv4, last_obs.udp}, 64'h0);
        chk("arp_eth_type", 64'(last_obs.typ), 64'h0806);

        build_frame(48'h0a0b0c0d0e0f, 48'h101112131415, 16'h0800, 8'h45, 8'h06,
                    32'hc0a80001, 32'hc0a80002, 16'd80, 16'd5555);
        drive_frame(80, 1'b1, -1);
        repeat (3) @(posedge clk156); @(negedge clk156);
        chk("tcp_flags", {61'h0, last_obs.runt, last_obs.ipv4, last_obs.udp}, 64'h2);
        chk("tcp_proto", 64'(last_obs.proto), 64'h06);

        build_udp_ref(); drive_frame(24, 1'b0, -1);
        build_udp_ref(); drive_frame(64, 1'b0, -1);
        repeat (3) @(posedge clk156); #1;

        build_udp_ref(); drive_frame(64, 1'b0, 2);
        repeat (2) @(posedge clk156); #1;
        s0 = n_strobe; build_udp_ref(); drive_frame(64, 1'b0, -1); check_udp_ref("post_reset", s0);

        for (int f = 0; f < 40; f++) begin
            logic [15:0] typ;
            logic [7:0]  vih, proto;
            int sel = $urandom_range(0, 3);
            typ   = (sel == 0) ? 16'h0806 : (sel == 3) ? 16'($urandom) : 16'h0800;
            vih   = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h45;
            proto = ($urandom_range(0, 2) == 0) ? 8'h06 : (($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h11);
            build_frame({$urandom, $urandom}, {$urandom, $urandom}, typ, vih, proto,
                        $urandom, $urandom, 16'($urandom), 16'($urandom));
            drive_frame($urandom_range(1, 100), $urandom_range(0, 1) == 1, -1);
            repeat ($urandom_range(0, 2)) @(posedge clk156);
            #1;
        end

        repeat (10) @(posedge clk156);
        @(negedge clk156);
        chk("pending_expected", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
